// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a loadable up-counter: each accepted command runs
// N segments of load / count-run / idle-gap, then samples the final count into result.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// LOAD   | one-cycle load strobe of the current segment value
// RUN    | counter enabled for run cycles
// GAP    | counter held for gap cycles
// DONE   | one-cycle done pulse, final count captured
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_start,
  input  logic [WIDTH-1:0] req_step,
  input  logic [LEN_W-1:0] req_run,
  input  logic [LEN_W-1:0] req_gap,
  input  logic [REP_W-1:0] req_segs,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] tmr_q, tmr_d;
  logic [REP_W-1:0] segs_q, segs_d;
  logic             seg_end;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    step_d   = step_q;
    result_d = result_q;
    run_d    = run_q;
    gap_d    = gap_q;
    tmr_d    = tmr_q;
    segs_d   = segs_q;
    seg_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_d   = req_start;
          step_d  = req_step;
          run_d   = req_run;
          gap_d   = req_gap;
          segs_d  = (req_segs == '0) ? REP_W'(1) : req_segs;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (run_q != '0) begin
          state_d = S_RUN;
          tmr_d   = run_q - LEN_W'(1);
        end else if (gap_q != '0) begin
          state_d = S_GAP;
          tmr_d   = gap_q - LEN_W'(1);
        end else begin
          seg_end = 1'b1;
        end
      end
      S_RUN: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - LEN_W'(1);
        end else if (gap_q != '0) begin
          state_d = S_GAP;
          tmr_d   = gap_q - LEN_W'(1);
        end else begin
          seg_end = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q != '0) tmr_d = tmr_q - LEN_W'(1);
        else             seg_end = 1'b1;
      end
      S_DONE: begin
        result_d = cnt_count;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (seg_end) begin
      segs_d = segs_q - REP_W'(1);
      if (segs_q > REP_W'(1)) begin
        cur_d   = cur_q + step_q;
        state_d = S_LOAD;
      end else begin
        state_d = S_DONE;
      end
    end

    // Abort freezes everything visible: cnt_data keeps the aborted segment value.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cur_d    = cur_q;
      segs_d   = segs_q;
      tmr_d    = tmr_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
      run_q    <= '0;
      gap_q    <= '0;
      tmr_q    <= '0;
      segs_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      step_q   <= step_d;
      result_q <= result_d;
      run_q    <= run_d;
      gap_q    <= gap_d;
      tmr_q    <= tmr_d;
      segs_q   <= segs_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign cnt_load   = (state_q == S_LOAD);
  assign cnt_enable = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign cnt_data   = cur_q;
  assign result     = result_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural up-counter closes the loop, and each
// command is checked against load values, enable totals, done timing and result.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_start, req_step;
  logic [7:0] req_run, req_gap;
  logic [2:0] req_segs;
  logic       abort;
  logic [3:0] cnt_count = 4'd0;
  logic       cnt_load, cnt_enable, busy, done;
  logic [3:0] cnt_data, result;

  int tests_run = 0;
  int failed    = 0;

  counter_sequencer #(.WIDTH(4), .LEN_W(8), .REP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_step(req_step),
    .req_run(req_run), .req_gap(req_gap), .req_segs(req_segs),
    .abort(abort), .cnt_count(cnt_count),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_enable(cnt_enable),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // The controlled counter: load wins, otherwise +1 per enabled cycle.
  always @(posedge clk) begin
    if (cnt_load)        cnt_count <= cnt_data;
    else if (cnt_enable) cnt_count <= cnt_count + 4'd1;
  end

  task automatic set_fields(input int start, input int step, input int run,
                            input int gap, input int segs);
    req_start = 4'(start);
    req_step  = 4'(step);
    req_run   = 8'(run);
    req_gap   = 8'(gap);
    req_segs  = 3'(segs);
  endtask

  // Issues one command and checks the whole sequence against arithmetic expectations.
  task automatic drive_sequence(input string name, input int start, input int step,
                                input int run, input int gap, input int segs);
    int eff, exp_done, exp_res, cyc, done_cyc, n_en, n_bad, wait_n, bad_load;
    logic [3:0] loads[$];
    eff      = (segs == 0) ? 1 : segs;
    exp_done = eff * (1 + run + gap) + 1;
    exp_res  = (start + (eff - 1) * step + run) % 16;

    @(negedge clk);
    set_fields(start, step, run, gap, segs);
    req_valid = 1'b1;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    cyc = 0; done_cyc = 0; n_en = 0; n_bad = 0;
    loads.delete();
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cnt_load)              loads.push_back(cnt_data);
      if (cnt_enable)            n_en++;
      if (cnt_load && cnt_enable) n_bad++;
      if (done === 1'b1)         done_cyc = cyc;
    end

    tests_run++;
    if (done_cyc != exp_done) begin
      failed++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end

    bad_load = (loads.size() != eff) ? 1 : 0;
    for (int i = 0; i < loads.size() && i < eff; i++)
      if (loads[i] !== 4'((start + i * step) % 16)) bad_load = 1;
    tests_run++;
    if (bad_load != 0) begin
      failed++;
      $display("FAIL %s loads: got %0d loads first=%0d required %0d loads first=%0d",
               name, loads.size(), (loads.size() > 0) ? int'(loads[0]) : -1, eff, start);
    end

    tests_run++;
    if (n_en != eff * run) begin
      failed++;
      $display("FAIL %s enable_cycles: got %0d required %0d", name, n_en, eff * run);
    end

    tests_run++;
    if (n_bad != 0) begin
      failed++;
      $display("FAIL %s load_and_enable: got %0d overlapping cycles required 0", name, n_bad);
    end

    @(negedge clk);
    tests_run++;
    if (result !== 4'(exp_res) || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s after_done: result=%0d done=%b busy=%b ready=%b required result=%0d 0 0 1",
               name, result, done, busy, req_ready, exp_res);
    end
  endtask

  task automatic test_reset();
    int cyc, seen_done;
    rst = 1'b0; req_valid = 1'b0; abort = 1'b0;
    set_fields(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #2;
    tests_run++;
    if (req_ready !== 1'b0 || cnt_load !== 1'b0 || cnt_enable !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || cnt_data !== 4'd0 || result !== 4'd0) begin
      failed++;
      $display("FAIL reset_values: ready=%b load=%b en=%b busy=%b done=%b data=%0d result=%0d required all 0",
               req_ready, cnt_load, cnt_enable, busy, done, cnt_data, result);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
    end

    // Reset in the middle of a RUN phase.
    set_fields(5, 1, 8, 2, 3);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cnt_enable !== 1'b1) begin
      failed++;
      $display("FAIL reset_pre_run: cnt_enable=%b required 1", cnt_enable);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (cnt_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cnt_load !== 1'b0 ||
        req_ready !== 1'b0 || cnt_data !== 4'd0) begin
      failed++;
      $display("FAIL reset_mid_run: en=%b busy=%b done=%b load=%b ready=%b data=%0d required 0s",
               cnt_enable, busy, done, cnt_load, req_ready, cnt_data);
    end
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    tests_run++;
    if (req_ready !== 1'b1 || seen_done != 0) begin
      failed++;
      $display("FAIL reset_after: ready=%b busy_or_done_cycles=%0d required 1 0", req_ready, seen_done);
    end
  endtask

  task automatic test_directed();
    drive_sequence("single",   10, 0, 5, 0, 1);
    drive_sequence("repeat",   10, 2, 3, 1, 3);
    drive_sequence("zero_len", 15, 3, 0, 0, 2);
    drive_sequence("segs_zero", 7, 5, 2, 2, 0);
    drive_sequence("gap_only", 4, 9, 0, 3, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      drive_sequence($sformatf("rand%0d", i), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
  endtask

  // Abort in the GAP of segment seg_idx, k cycles into that gap.
  task automatic test_abort(input string name, input int start, input int step, input int run,
                            input int gap, input int segs, input int seg_idx, input int k);
    int abort_cyc, seen;
    logic [3:0] prior;
    prior = result;
    abort_cyc = seg_idx * (1 + run + gap) + 1 + run + k;
    @(negedge clk);
    set_fields(start, step, run, gap, segs);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (abort_cyc) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || cnt_enable !== 1'b0 || cnt_load !== 1'b0) begin
      failed++;
      $display("FAIL %s in_gap: busy=%b en=%b load=%b required 1 0 0", name, busy, cnt_enable, cnt_load);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || cnt_enable !== 1'b0 || cnt_load !== 1'b0 ||
        cnt_data !== 4'((start + seg_idx * step) % 16)) begin
      failed++;
      $display("FAIL %s after_abort: busy=%b ready=%b en=%b load=%b data=%0d required 0 1 0 0 %0d",
               name, busy, req_ready, cnt_enable, cnt_load, cnt_data, (start + seg_idx * step) % 16);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0 || result !== prior) begin
      failed++;
      $display("FAIL %s no_done: active_cycles=%0d result=%0d required 0 %0d", name, seen, result, prior);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, done_cyc, ready_hi, n_load, wait_n;
    @(negedge clk);
    set_fields(3, 1, 2, 1, 2);
    req_valid = 1'b1;
    @(posedge clk);
    #1 set_fields(9, 1, 2, 1, 2);
    cyc = 0; done_cyc = 0; ready_hi = 0; n_load = 0;
    while (done_cyc == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (req_ready === 1'b1) ready_hi++;
      if (cnt_load)           n_load++;
      if (done === 1'b1)      done_cyc = cyc;
    end
    tests_run++;
    if (done_cyc != 9 || ready_hi != 0 || n_load != 2) begin
      failed++;
      $display("FAIL b2b_first: done_cycle=%0d ready_cycles=%0d loads=%0d required 9 0 2",
               done_cyc, ready_hi, n_load);
    end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || result !== 4'd6) begin
      failed++;
      $display("FAIL b2b_gap_cycle: ready=%b result=%0d required 1 6", req_ready, result);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (cnt_load !== 1'b1 || cnt_data !== 4'd9) begin
      failed++;
      $display("FAIL b2b_second_load: load=%b data=%0d required 1 9", cnt_load, cnt_data);
    end
    wait_n = 0;
    while (done !== 1'b1 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    tests_run++;
    if (result !== 4'd12 || busy !== 1'b0) begin
      failed++;
      $display("FAIL b2b_second_result: result=%0d busy=%b required 12 0", result, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort("abort_t3", 10, 2, 3, 1, 3, 1, 1);
    test_abort("abort_rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 4)), 4, 3, int'($urandom_range(0, 2)),
               int'($urandom_range(1, 4)));
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
